// File: rtl/pe_pkg.sv
// Shared constants for the PE subtractor pipeline.
//   PE_WIDTH     operand/result width
//   PE_SLICE     bits resolved per pipeline stage
//   slice_count  number of slice stages for a given width/slice pair
package pe_pkg;

    localparam int PE_WIDTH = 64;
    localparam int PE_SLICE = 16;

    function automatic int slice_count(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/pe_sub64_pipe_if.sv
// Handshake bundle for the pipelined subtractor.
//   in_valid/in_ready    operand-side handshake, operands in_a, in_b, in_bin
//   out_valid/out_ready  result-side handshake, result out_diff and flags
//   master modport: producer/consumer side (testbench or upstream logic)
//   slave modport:  the subtractor itself
interface pe_sub64_pipe_if
    import pe_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_bout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_bin, out_ready,
        input  in_ready, out_valid, out_diff, out_bout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_bin, out_ready,
        output in_ready, out_valid, out_diff, out_bout, out_ovf, out_zero
    );
endinterface

// File: rtl/pe_sub_slice.sv
// Combinational SLICE-bit subtract with borrow: diff = a - b - bin.
//   a_i, b_i  operand slices
//   bin_i     borrow in from the slice below
//   diff_o    result slice
//   bout_o    borrow out to the slice above
module pe_sub_slice
    import pe_pkg::*;
#(
    parameter int SLICE = PE_SLICE
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             bin_i,
    output logic [SLICE-1:0] diff_o,
    output logic             bout_o
);
    logic [SLICE:0] sum;

    // Subtraction as a + ~b + ~bin; a borrow is the absence of a carry.
    assign sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{SLICE{1'b0}}, ~bin_i};
    assign diff_o = sum[SLICE-1:0];
    assign bout_o = ~sum[SLICE];
endmodule

// File: rtl/pe_sub64_pipe.sv
// Pipelined WIDTH-bit subtractor with borrow, one SLICE resolved per stage.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of pe_sub64_pipe_if (operand and result handshakes)
// Register 0 captures the operands; slice k is computed from register k and
// lands in register k+1; the last slice plus the flags land in the output
// register, giving STAGES cycles from acceptance to out_valid.
module pe_sub64_pipe
    import pe_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    parameter int SLICE = PE_SLICE
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_sub64_pipe_if.slave        bus
);
    localparam int STAGES = slice_count(WIDTH, SLICE);

    // Index STAGES is the output register.
    logic [STAGES:0] v_q;
    logic [STAGES:0] v_d;
    logic [STAGES:0] adv;
    logic [STAGES:0] ld;
    logic            in_rdy;

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] dif_q [STAGES];
    logic             bor_q [STAGES];

    logic [STAGES-1:0][SLICE-1:0] sdiff;
    logic [STAGES-1:0]            sbout;

    logic [WIDTH-1:0] fin_diff;
    logic             fin_ovf;

    logic [WIDTH-1:0] out_diff_q;
    logic             out_bout_q;
    logic             out_ovf_q;
    logic             out_zero_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        pe_sub_slice #(.SLICE(SLICE)) u_slice (
            .a_i    (a_q[k][k*SLICE +: SLICE]),
            .b_i    (b_q[k][k*SLICE +: SLICE]),
            .bin_i  (bor_q[k]),
            .diff_o (sdiff[k]),
            .bout_o (sbout[k])
        );
    end

    // Advance chain resolved from the output backwards: a stage moves when
    // it holds data and the stage after it is empty or moving too.
    always_comb begin
        adv         = '0;
        ld          = '0;
        v_d         = '0;
        adv[STAGES] = v_q[STAGES] & bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
        end
        in_rdy = ~rst & (~v_q[0] | adv[0]);
        ld[0]  = bus.in_valid & in_rdy;
        for (int k = 1; k <= STAGES; k++) begin
            ld[k] = adv[k-1];
        end
        for (int k = 0; k <= STAGES; k++) begin
            v_d[k] = ld[k] | (v_q[k] & ~adv[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    // Operand capture and slice stages: each carries the pending operands,
    // the diff slices done so far and the borrow for the next slice.
    always_ff @(posedge clk) begin
        if (ld[0]) begin
            a_q[0]   <= bus.in_a;
            b_q[0]   <= bus.in_b;
            dif_q[0] <= '0;
            bor_q[0] <= bus.in_bin;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (ld[k]) begin
                a_q[k]                          <= a_q[k-1];
                b_q[k]                          <= b_q[k-1];
                dif_q[k]                        <= dif_q[k-1];
                dif_q[k][(k-1)*SLICE +: SLICE]  <= sdiff[k-1];
                bor_q[k]                        <= sbout[k-1];
            end
        end
    end

    always_comb begin
        fin_diff                               = dif_q[STAGES-1];
        fin_diff[(STAGES-1)*SLICE +: SLICE]    = sdiff[STAGES-1];
    end

    // Signed overflow only when the operand signs differ and the result sign
    // disagrees with the minuend.
    assign fin_ovf = (a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]) &
                     (fin_diff[WIDTH-1] ^ a_q[STAGES-1][WIDTH-1]);

    // Output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_diff_q <= '0;
            out_bout_q <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_zero_q <= 1'b0;
        end else if (ld[STAGES]) begin
            out_diff_q <= fin_diff;
            out_bout_q <= sbout[STAGES-1];
            out_ovf_q  <= fin_ovf;
            out_zero_q <= (fin_diff == '0);
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = v_q[STAGES];
    assign bus.out_diff  = out_diff_q;
    assign bus.out_bout  = out_bout_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_zero  = out_zero_q;
endmodule

// File: tb/tb_pe_sub64_pipe.sv
module tb_pe_sub64_pipe;
    import pe_pkg::*;

    localparam int W    = PE_WIDTH;
    localparam int LAT  = PE_WIDTH / PE_SLICE;
    localparam int NREG = LAT + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pe_sub64_pipe_if #(.WIDTH(W)) bus();

    pe_sub64_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain wide arithmetic, unsigned for the borrow, signed for overflow.
    function automatic res_t ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        res_t               r;
        logic [W:0]         u;
        logic signed [W+1:0] s;
        u = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        s = $signed({a[W-1], a[W-1], a}) - $signed({b[W-1], b[W-1], b})
            - $signed({{(W+1){1'b0}}, bin});
        r.d    = u[W-1:0];
        r.bout = u[W];
        r.ovf  = (s[W] != s[W-1]);
        r.zero = (u[W-1:0] == '0);
        return r;
    endfunction

    logic [W-1:0] d_a   [7] = '{64'd5, 64'd0, 64'h8000_0000_0000_0000, 64'h0001_0000_0000_0000,
                                64'd7, 64'd7, 64'd0};
    logic [W-1:0] d_b   [7] = '{64'd3, 64'd1, 64'd1, 64'd1, 64'd7, 64'd7, 64'd0};
    logic         d_bin [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] d_exp [7] = '{64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                                64'h0000_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                                64'hFFFF_FFFF_FFFF_FFFF};
    logic         d_bo  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         d_ov  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic         d_zr  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_bin    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        else n_pass++;
        n_chk++;
        if ({bus.out_diff, bus.out_bout, bus.out_ovf, bus.out_zero} !== '0)
            $display("FAIL reset_outputs: got %h/%b%b%b want 0", bus.out_diff, bus.out_bout, bus.out_ovf, bus.out_zero);
        else n_pass++;
        n_chk++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready_low: got %b want 0", bus.in_ready);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_release: got %b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        int lat;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_a      = d_a[i];
            bus.in_b      = d_b[i];
            bus.in_bin    = d_bin[i];
            bus.out_ready = 1'b1;
            #1;
            n_chk++;
            if (bus.in_ready !== 1'b1) $display("FAIL dir%0d_in_ready: got %b want 1", i, bus.in_ready);
            else n_pass++;
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat = 0;
            while (bus.out_valid !== 1'b1 && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            n_chk++;
            if (lat != LAT) $display("FAIL dir%0d_latency: got %0d cycles want %0d", i, lat, LAT);
            else n_pass++;
            n_chk++;
            if (bus.out_diff !== d_exp[i]) $display("FAIL dir%0d_diff: got %h want %h", i, bus.out_diff, d_exp[i]);
            else n_pass++;
            n_chk++;
            if ({bus.out_bout, bus.out_ovf, bus.out_zero} !== {d_bo[i], d_ov[i], d_zr[i]})
                $display("FAIL dir%0d_flags bout/ovf/zero: got %b%b%b want %b%b%b", i,
                         bus.out_bout, bus.out_ovf, bus.out_zero, d_bo[i], d_ov[i], d_zr[i]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        res_t         expq[$];
        res_t         e;
        int           acc = 0, emit = 0, occ = 0, cyc = 0;
        int           a_now, e_now;
        logic [W-1:0] a = '0, b = '0;
        logic         bin = 1'b0, pend = 1'b0, stall_prev = 1'b0, exp_rdy;
        logic [W+2:0] prev_out = '0;
        while (emit < 16 && cyc < 400) begin
            @(negedge clk);
            if (stall_prev) begin
                n_chk++;
                if ({bus.out_valid, bus.out_diff, bus.out_bout, bus.out_ovf, bus.out_zero} !== {1'b1, prev_out})
                    $display("FAIL b2b_stall_hold cyc%0d: got %h want %h", cyc,
                             {bus.out_diff, bus.out_bout, bus.out_ovf, bus.out_zero}, prev_out);
                else n_pass++;
            end
            if (!pend && acc < 16) begin
                a    = {$urandom, $urandom};
                b    = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
                bin  = 1'($urandom_range(0, 1));
                pend = 1'b1;
            end
            bus.in_valid  = pend;
            bus.in_a      = a;
            bus.in_b      = b;
            bus.in_bin    = bin;
            bus.out_ready = (cyc % 3 == 0);
            #1;
            exp_rdy = !(occ == NREG && !bus.out_ready);
            n_chk++;
            if (bus.in_ready !== exp_rdy)
                $display("FAIL b2b_in_ready cyc%0d occ%0d: got %b want %b", cyc, occ, bus.in_ready, exp_rdy);
            else n_pass++;
            a_now = 0;
            e_now = 0;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                n_chk++;
                if (expq.size() == 0) begin
                    $display("FAIL b2b_spurious cyc%0d: got result %h want none", cyc, bus.out_diff);
                end else begin
                    e = expq.pop_front();
                    if ({bus.out_diff, bus.out_bout, bus.out_ovf, bus.out_zero} !== {e.d, e.bout, e.ovf, e.zero})
                        $display("FAIL b2b_result%0d: got %h/%b%b%b want %h/%b%b%b", emit,
                                 bus.out_diff, bus.out_bout, bus.out_ovf, bus.out_zero, e.d, e.bout, e.ovf, e.zero);
                    else n_pass++;
                end
                emit++;
                e_now = 1;
            end
            if (pend && bus.in_ready === 1'b1) begin
                expq.push_back(ref_sub(a, b, bin));
                acc++;
                a_now = 1;
                pend  = 1'b0;
            end
            occ        = occ + a_now - e_now;
            stall_prev = (bus.out_valid === 1'b1) && !bus.out_ready;
            prev_out   = {bus.out_diff, bus.out_bout, bus.out_ovf, bus.out_zero};
            cyc++;
        end
        n_chk++;
        if (emit != 16 || expq.size() != 0)
            $display("FAIL b2b_count: got %0d results (%0d pending) want 16", emit, expq.size());
        else n_pass++;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_flush();
        res_t         e;
        logic [W-1:0] a, b;
        logic         seen = 1'b0;
        int           lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_a      = 64'(i + 100);
            bus.in_b      = 64'(i);
            bus.in_bin    = 1'b0;
            bus.out_ready = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b0) $display("FAIL flush_in_ready_in_reset: got %b want 0", bus.in_ready);
        else n_pass++;
        @(negedge clk);
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        n_chk++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid_after_rst: got %b want 0", bus.out_valid);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) $display("FAIL flush_stale_result: got out_valid 1 want 0");
        else n_pass++;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        e = ref_sub(a, b, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_bin   = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        n_chk++;
        if (lat != LAT) $display("FAIL flush_new_latency: got %0d cycles want %0d", lat, LAT);
        else n_pass++;
        n_chk++;
        if ({bus.out_diff, bus.out_bout, bus.out_ovf, bus.out_zero} !== {e.d, e.bout, e.ovf, e.zero})
            $display("FAIL flush_new_result: got %h/%b%b%b want %h/%b%b%b",
                     bus.out_diff, bus.out_bout, bus.out_ovf, bus.out_zero, e.d, e.bout, e.ovf, e.zero);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_flush();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
